// File: rtl/maxfinder_loader.sv
// Streams words into the maxfinder memory at addresses 0..MAX_ADDR, pulses start,
// then blocks further loads until the finder reports completion.
module maxfinder_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int MAX_ADDR = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_abort,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_start,
  input  logic              i_finder_done,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_words_loaded
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [ADDR_W:0]   r_words_loaded, w_words_loaded_nxt;
  logic              w_accept;
  logic              w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_wr_addr      <= '0;
      r_words_loaded <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_wr_addr      <= w_wr_addr_nxt;
      r_words_loaded <= w_words_loaded_nxt;
    end
  end

  // Abort beats a simultaneous transfer: the word is dropped, not written.
  assign w_accept = (r_state == S_LOAD) && i_in_valid && !i_abort;
  assign w_last   = (r_wr_addr == ADDR_W'(MAX_ADDR));

  always_comb begin
    w_state_nxt        = r_state;
    w_wr_addr_nxt      = r_wr_addr;
    w_words_loaded_nxt = r_words_loaded;
    o_in_ready         = 1'b0;
    o_start            = 1'b0;
    o_busy             = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (i_load) begin
          w_state_nxt        = S_LOAD;
          w_wr_addr_nxt      = '0;
          w_words_loaded_nxt = '0;
        end
      end
      S_LOAD: begin
        o_in_ready = 1'b1;
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          w_words_loaded_nxt = r_words_loaded + 1'b1;
          if (w_last) w_state_nxt   = S_START;
          else        w_wr_addr_nxt = r_wr_addr + 1'b1;
        end
      end
      S_START: begin
        o_start     = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_finder_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_mem_we       = w_accept;
  assign o_mem_addr     = r_wr_addr;
  assign o_mem_wdata    = i_in_data;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_maxfinder_loader.sv
// Directed bench for maxfinder_loader: inputs driven and outputs sampled on the falling edge.
module tb_maxfinder_loader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int MAX_ADDR = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load, abort, in_valid, finder_done;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, mem_we, start, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maxfinder_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_abort(abort),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_start(start), .i_finder_done(finder_done), .o_busy(busy),
    .o_words_loaded(words_loaded)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_start"}, start, 0);
  endtask

  // Full load with in_valid held high through START, then a RUN phase where load is ignored.
  task automatic full_load(input string tag);
    load = 1'b1;
    step();
    load = 1'b0;
    #1 chk({tag, "_ready"}, in_ready, 1);
    for (int i = 0; i <= MAX_ADDR; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      #1;
      chk({tag, "_we"}, mem_we, 1);
      chk({tag, "_addr"}, mem_addr, i);
      chk({tag, "_data"}, mem_wdata, 32'h10 + i);
      chk({tag, "_nostart"}, start, 0);
      step();
    end
    #1;
    chk({tag, "_start"}, start, 1);
    chk({tag, "_st_ready"}, in_ready, 0);
    chk({tag, "_st_we"}, mem_we, 0);
    chk({tag, "_wl"}, words_loaded, 16);
    step();
    in_valid = 1'b0;
    load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk({tag, "_run_start"}, start, 0);
      chk({tag, "_run_ready"}, in_ready, 0);
      chk({tag, "_run_busy"}, busy, 1);
      step();
    end
    load = 1'b0;
    finder_done = 1'b1;
    step();
    #1 chk_idle({tag, "_done"});
    chk({tag, "_wl_hold"}, words_loaded, 16);
  endtask

  initial begin
    rst_n = 1'b0; load = 0; abort = 0; in_valid = 0; finder_done = 0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("rst");
    chk("rst_wl", words_loaded, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1 chk_idle("idle");
    end

    full_load("full1");

    // Stalled source, finder_done left high from the previous scan.
    begin
      int k = 0;
      int c = 0;
      load = 1'b1;
      step();
      load = 1'b0;
      while (k <= MAX_ADDR && c < 80) begin
        in_valid = (c % 3 == 0);
        in_data  = 8'hA0 + 8'(k);
        #1;
        chk("stall_we", mem_we, in_valid);
        chk("stall_start", start, 0);
        if (in_valid) begin
          chk("stall_addr", mem_addr, k);
          k++;
        end
        step();
        c++;
      end
      chk("stall_count", k, 16);
      in_valid = 1'b0;
      #1 chk("stall_pulse", start, 1);
      step();
      #1 chk("stall_run_busy", busy, 1);
      chk("stall_run_start", start, 0);
      step();
      #1 chk("stall_done_idle", busy, 0);
      finder_done = 1'b0;
    end

    // Abort at word 5 with a word offered the same cycle.
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    abort = 1'b1;
    #1 chk("abort_we", mem_we, 0);
    chk("abort_ready", in_ready, 1);
    step();
    abort = 1'b1; in_valid = 1'b0;
    #1 chk_idle("abort");
    chk("abort_wl", words_loaded, 5);
    // load and abort together in IDLE: load wins.
    load = 1'b1;
    step();
    load = 1'b0; abort = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    #1 chk("reload_busy", busy, 1);
    chk("reload_addr", mem_addr, 0);
    chk("reload_we", mem_we, 1);
    chk("reload_wl", words_loaded, 0);
    abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;

    // Async reset mid-LOAD at address 7.
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    #1 chk("pre_rst_addr", mem_addr, 7);
    #1 rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_wl", words_loaded, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    #1 chk_idle("post_rst");

    full_load("full2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
